roc_decoder: RTL and testbench
==============================

# roc_decoder

Receive side of the 10-bit rank-order-coded (ROC) AER link. It completes a 4-phase REQ/ACK handshake per word and detects the two-word reset marker that opens each frame. It records the arrival rank of every pixel index and exposes the rank table, or a rank-derived intensity, through a registered read port. It sits at the SNN-core input, mirroring the encoder on the transmit side, and supports loopback verification of the encoder.

## Interface
Parameters:
- IMAGE_SIZE, 256, pixels per frame; also the maximum number of data events.
- IMAGE_SIZE_BITS, $clog2(IMAGE_SIZE), index and rank width.
- PIXEL_MAX_VALUE, 255, brightest intensity.
- PIXEL_BITS, $clog2(PIXEL_MAX_VALUE), intensity width.

Ports:
- CLK  in  1  sole clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- AERIN_ADDR  in  10  AER word. 10'h1FF is the reset marker; {2'b00, idx} is a data event.
- AERIN_REQ  in  1  4-phase request.
- AERIN_ACK  out  1  4-phase acknowledge.
- RD_ADDR  in  IMAGE_SIZE_BITS  rank-table read index.
- RD_DATA  out  IMAGE_SIZE_BITS  registered rank (or intensity, see Configuration).
- RD_SEEN  out  1  registered; the indexed pixel arrived in the current frame.
- EVENT_COUNT  out  IMAGE_SIZE_BITS+1  data events accepted in the current frame.
- FRAME_OPEN  out  1  a frame is accepting data events.
- FRAME_DONE  out  1  level; EVENT_COUNT == IMAGE_SIZE.
- DECODE_ERR  out  1  one-cycle pulse on a dropped word.

## Operation
Handshake FSM:
- IDLE: ACK=0. When AERIN_REQ=1, latch AERIN_ADDR and go to CAPTURE.
- CAPTURE: one cycle; classify and process the latched word, then go to ACK.
- ACK: ACK=1. Hold until AERIN_REQ=0, then return to IDLE.

Marker handling:
- marker_cnt is 2 bits and saturates at 2.
- A marker word increments marker_cnt. The marker that makes it 2 starts a new frame in the same CAPTURE cycle: clear all seen bits, EVENT_COUNT=0, FRAME_OPEN=1, FRAME_DONE=0.
- Further markers while marker_cnt is 2: no effect, not an error.
- Any non-marker word sets marker_cnt=0.

Data event (AERIN_ADDR[9:8]==2'b00, idx=AERIN_ADDR[7:0]). It is accepted only if all of the following hold:
- FRAME_OPEN=1,
- idx < IMAGE_SIZE,
- seen[idx]=0.

On accept:
- rank[idx] = EVENT_COUNT[IMAGE_SIZE_BITS-1:0],
- seen[idx] = 1,
- EVENT_COUNT += 1.

When EVENT_COUNT reaches IMAGE_SIZE:
- FRAME_DONE=1, FRAME_OPEN=0 on the same edge.

Dropped words:
- Any non-accepted data word, and any word with AERIN_ADDR[9:8] other than 00 that is not 10'h1FF, is dropped.
- A drop pulses DECODE_ERR and leaves the table unchanged.
- A duplicate idx keeps its first rank.

Early stop:
- Unseen pixels at frame end read RD_SEEN=0 and RD_DATA=0.
- The next double marker reopens the frame.

## Timing
- Reset values: AERIN_ACK=0, RD_DATA=0, RD_SEEN=0, EVENT_COUNT=0, FRAME_OPEN=0, FRAME_DONE=0, DECODE_ERR=0, marker_cnt=0, FSM=IDLE, all seen bits=0.
- Rank storage contents after reset are don't-care; they are masked by the seen bits.
- Handshake: with REQ sampled high at edge N, the address is latched at N. Table, counters and DECODE_ERR update at N+1 (end of CAPTURE). AERIN_ACK is high from N+2 until the edge after REQ is sampled low.
- Minimum word period: 4 cycles when REQ falls immediately after ACK.
- Read port: RD_DATA and RD_SEEN reflect RD_ADDR and the table state as of the previous edge, with 1-cycle latency. A read of the index written in CAPTURE returns the new value one cycle after that CAPTURE edge.
- REQ already high on return to IDLE: treated as a new word at that edge. The sender must drop REQ between words.
- Reset mid-handshake: ACK is low the cycle after RST is sampled, and the frame is closed. The sender must restart with markers.
- The frame-start clear and the accepting of a data word never coincide, because each word uses its own CAPTURE cycle.

## Configuration
- ROC_DECODER_INTENSITY_EN defined: RD_DATA = PIXEL_MAX_VALUE − rank, saturating at 0, truncated to the port width. Unseen pixels read 0.
- Macro undefined: RD_DATA = raw rank.
- Storage and handshake are identical in both builds.

## Test plan
- Reset, then 10'h1FF, 10'h1FF, 0x005, 0x003 → FRAME_OPEN=1, rank[5]=0, rank[3]=1, EVENT_COUNT=2, ACK high 2 cycles after each REQ rise.
- Data 0x007 sent before any marker → DECODE_ERR pulse, seen[7]=0, EVENT_COUNT=0, handshake still completes.
- After the double marker, send 0x009 twice → second word gives DECODE_ERR, rank[9]=0, EVENT_COUNT=1.
- Send all 256 indices in descending order → FRAME_DONE=1, FRAME_OPEN=0, rank[255]=0, rank[0]=255. A 257th word gives DECODE_ERR.
- Marker, 0x004, marker → no new frame (marker_cnt was reset), table kept. A following second marker clears it: RD_SEEN(4)=0.
- With ROC_DECODER_INTENSITY_EN: first event idx 12 → RD_DATA(12)=255, the second event reads 254. Assert RST while ACK=1 → ACK=0 next cycle, all outputs at reset values.

Source files
------------

// File: rtl/roc_decoder.sv
// roc_decoder: receive side of the 10-bit rank-order-coded AER link.
// Completes a 4-phase REQ/ACK handshake per word, detects the two-word
// reset marker (10'h1FF twice) that opens a frame, records the arrival rank of
// each pixel index and exposes rank (or rank-derived intensity) on a
// registered read port.
//
// Optional feature macro: ROC_DECODER_INTENSITY_EN
//   defined   : RD_DATA = PIXEL_MAX_VALUE - rank (saturating at 0)
//   undefined : RD_DATA = raw rank
//
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   AERIN_ADDR    incoming AER word (marker 10'h1FF or {2'b00, idx})
//   AERIN_REQ     4-phase request from sender
//   AERIN_ACK     4-phase acknowledge to sender
//   RD_ADDR       rank-table read index
//   RD_DATA       registered rank / intensity of RD_ADDR
//   RD_SEEN       registered seen flag of RD_ADDR
//   EVENT_COUNT   data events accepted in current frame
//   FRAME_OPEN    frame is accepting data events
//   FRAME_DONE    EVENT_COUNT == IMAGE_SIZE
//   DECODE_ERR    one-cycle pulse on a dropped word
module roc_decoder #(
  parameter int unsigned IMAGE_SIZE      = 256,
  parameter int unsigned IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int unsigned PIXEL_MAX_VALUE = 255,
  parameter int unsigned PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE)
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [9:0]                 AERIN_ADDR,
  input  logic                       AERIN_REQ,
  output logic                       AERIN_ACK,
  input  logic [IMAGE_SIZE_BITS-1:0] RD_ADDR,
  output logic [IMAGE_SIZE_BITS-1:0] RD_DATA,
  output logic                       RD_SEEN,
  output logic [IMAGE_SIZE_BITS:0]   EVENT_COUNT,
  output logic                       FRAME_OPEN,
  output logic                       FRAME_DONE,
  output logic                       DECODE_ERR
);

  localparam int unsigned CW = IMAGE_SIZE_BITS + 1;
  localparam logic [9:0]  MARKER = 10'h1FF;
`ifdef ROC_DECODER_INTENSITY_EN
  localparam bit INTENSITY_EN = 1'b1;
`else
  localparam bit INTENSITY_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_ACK     = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [9:0]                 addr_q, addr_d;
  logic [1:0]                 mk_q, mk_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       open_q, open_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;
  logic                       ack_q, ack_d;
  logic [IMAGE_SIZE-1:0]      seen_q, seen_d;
  logic [IMAGE_SIZE_BITS-1:0] rd_data_q, rd_data_d;
  logic                       rd_seen_q, rd_seen_d;

  logic [IMAGE_SIZE_BITS-1:0] rank_mem [IMAGE_SIZE];
  logic                       rank_we;
  logic [IMAGE_SIZE_BITS-1:0] rank_idx;
  logic [IMAGE_SIZE_BITS-1:0] rank_wdata;
  logic [IMAGE_SIZE_BITS-1:0] rank_rd;

  logic is_marker;
  logic in_range;
  logic accept;

  // Classification of the latched word
  assign is_marker = (addr_q == MARKER);
  assign in_range  = ({22'd0, addr_q[7:0]} < IMAGE_SIZE);
  assign accept    = (addr_q[9:8] == 2'b00) && open_q && in_range
                     && !seen_q[rank_idx];
  assign rank_rd   = rank_mem[RD_ADDR];

  // Next-state, table update and read-port logic
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    mk_d       = mk_q;
    cnt_d      = cnt_q;
    open_d     = open_q;
    done_d     = done_q;
    seen_d     = seen_q;
    err_d      = 1'b0;
    ack_d      = 1'b0;
    rank_we    = 1'b0;
    rank_idx   = IMAGE_SIZE_BITS'(addr_q[7:0]);
    rank_wdata = cnt_q[IMAGE_SIZE_BITS-1:0];

    unique case (state_q)
      ST_IDLE: begin
        if (AERIN_REQ) begin
          addr_d  = AERIN_ADDR;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        state_d = ST_ACK;
        if (is_marker) begin
          // Second consecutive marker opens a fresh frame
          if (mk_q == 2'd1) begin
            seen_d = '0;
            cnt_d  = '0;
            open_d = 1'b1;
            done_d = 1'b0;
          end
          if (mk_q != 2'd2) begin
            mk_d = mk_q + 2'd1;
          end
        end else begin
          mk_d = 2'd0;
          if (accept) begin
            rank_we          = 1'b1;
            seen_d[rank_idx] = 1'b1;
            cnt_d            = cnt_q + CW'(1);
            if (cnt_d == CW'(IMAGE_SIZE)) begin
              done_d = 1'b1;
              open_d = 1'b0;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_ACK: begin
        // ACK rises one cycle after entering this state, drops as REQ falls
        if (!AERIN_REQ) begin
          state_d = ST_IDLE;
        end else begin
          ack_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rd_seen_d = seen_q[RD_ADDR];
    if (!seen_q[RD_ADDR]) begin
      rd_data_d = '0;
    end else if (INTENSITY_EN) begin
      if (32'(rank_rd) > PIXEL_MAX_VALUE) begin
        rd_data_d = '0;
      end else begin
        rd_data_d = IMAGE_SIZE_BITS'(PIXEL_BITS'(PIXEL_MAX_VALUE - 32'(rank_rd)));
      end
    end else begin
      rd_data_d = rank_rd;
    end
  end

  // State and control registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      mk_q      <= '0;
      cnt_q     <= '0;
      open_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ack_q     <= 1'b0;
      seen_q    <= '0;
      rd_data_q <= '0;
      rd_seen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      mk_q      <= mk_d;
      cnt_q     <= cnt_d;
      open_q    <= open_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ack_q     <= ack_d;
      seen_q    <= seen_d;
      rd_data_q <= rd_data_d;
      rd_seen_q <= rd_seen_d;
    end
  end

  // Rank storage; contents are masked by the seen bits, so no reset
  always_ff @(posedge CLK) begin
    if (rank_we) begin
      rank_mem[rank_idx] <= rank_wdata;
    end
  end

  assign AERIN_ACK   = ack_q;
  assign RD_DATA     = rd_data_q;
  assign RD_SEEN     = rd_seen_q;
  assign EVENT_COUNT = cnt_q;
  assign FRAME_OPEN  = open_q;
  assign FRAME_DONE  = done_q;
  assign DECODE_ERR  = err_q;

endmodule

// File: tb/tb_roc_decoder.sv
// Testbench for roc_decoder: directed and random AER words checked against a
// frame-level reference model (per-pixel seen/rank arrays and an event count).
module tb_roc_decoder;

  localparam int IMAGE_SIZE = 256;
`ifdef ROC_DECODER_INTENSITY_EN
  localparam bit INTENS = 1'b1;
`else
  localparam bit INTENS = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic [9:0] AERIN_ADDR;
  logic       AERIN_REQ;
  logic       AERIN_ACK;
  logic [7:0] RD_ADDR;
  logic [7:0] RD_DATA;
  logic       RD_SEEN;
  logic [8:0] EVENT_COUNT;
  logic       FRAME_OPEN;
  logic       FRAME_DONE;
  logic       DECODE_ERR;

  roc_decoder dut (
    .CLK        (CLK),
    .RST        (RST),
    .AERIN_ADDR (AERIN_ADDR),
    .AERIN_REQ  (AERIN_REQ),
    .AERIN_ACK  (AERIN_ACK),
    .RD_ADDR    (RD_ADDR),
    .RD_DATA    (RD_DATA),
    .RD_SEEN    (RD_SEEN),
    .EVENT_COUNT(EVENT_COUNT),
    .FRAME_OPEN (FRAME_OPEN),
    .FRAME_DONE (FRAME_DONE),
    .DECODE_ERR (DECODE_ERR)
  );

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model state
  bit m_seen [IMAGE_SIZE];
  int m_rank [IMAGE_SIZE];
  int m_cnt;
  bit m_open;
  int m_mk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_seen[i]) m_seen[i] = 1'b0;
    m_cnt  = 0;
    m_open = 1'b0;
    m_mk   = 0;
  endtask

  task automatic model_word(input logic [9:0] a, output bit err);
    int idx;
    err = 1'b0;
    if (a == 10'h1FF) begin
      if (m_mk == 1) begin
        foreach (m_seen[i]) m_seen[i] = 1'b0;
        m_cnt  = 0;
        m_open = 1'b1;
      end
      if (m_mk < 2) m_mk++;
    end else begin
      m_mk = 0;
      idx  = int'(a[7:0]);
      if (a[9:8] != 2'b00 || !m_open || m_seen[idx]) begin
        err = 1'b1;
      end else begin
        m_seen[idx] = 1'b1;
        m_rank[idx] = m_cnt;
        m_cnt++;
        if (m_cnt == IMAGE_SIZE) m_open = 1'b0;
      end
    end
  endtask

  function automatic int exp_rd(input int idx);
    if (!m_seen[idx]) return 0;
    if (INTENS) return (m_rank[idx] > 255) ? 0 : (255 - m_rank[idx]);
    return m_rank[idx] & 255;
  endfunction

  // One full handshake, starting and ending at a falling clock edge
  task automatic send_word(input logic [9:0] a);
    bit e;
    model_word(a, e);
    AERIN_ADDR = a;
    AERIN_REQ  = 1'b1;
    @(posedge CLK); @(negedge CLK);
    check("ack_low_latch", 32'(AERIN_ACK), 32'd0);
    @(posedge CLK); @(negedge CLK);
    check("decode_err", 32'(DECODE_ERR), 32'(e));
    check("event_count", 32'(EVENT_COUNT), 32'(m_cnt));
    check("frame_open", 32'(FRAME_OPEN), 32'(m_open));
    check("frame_done", 32'(FRAME_DONE), 32'(m_cnt == IMAGE_SIZE));
    check("ack_low_capture", 32'(AERIN_ACK), 32'd0);
    @(posedge CLK); @(negedge CLK);
    check("ack_high", 32'(AERIN_ACK), 32'd1);
    check("err_pulse_end", 32'(DECODE_ERR), 32'd0);
    AERIN_REQ = 1'b0;
    @(posedge CLK); @(negedge CLK);
    check("ack_release", 32'(AERIN_ACK), 32'd0);
  endtask

  task automatic read_check(input int idx);
    RD_ADDR = 8'(idx);
    @(posedge CLK); @(negedge CLK);
    check($sformatf("rd_seen[%0d]", idx), 32'(RD_SEEN), 32'(m_seen[idx]));
    check($sformatf("rd_data[%0d]", idx), 32'(RD_DATA), 32'(exp_rd(idx)));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, 32'(AERIN_ACK), 32'd0);
    check({tag, "_rd_data"}, 32'(RD_DATA), 32'd0);
    check({tag, "_rd_seen"}, 32'(RD_SEEN), 32'd0);
    check({tag, "_event_count"}, 32'(EVENT_COUNT), 32'd0);
    check({tag, "_frame_open"}, 32'(FRAME_OPEN), 32'd0);
    check({tag, "_frame_done"}, 32'(FRAME_DONE), 32'd0);
    check({tag, "_decode_err"}, 32'(DECODE_ERR), 32'd0);
  endtask

  initial begin
    logic [9:0] w;
    int sel;
    RST        = 1'b1;
    AERIN_ADDR = '0;
    AERIN_REQ  = 1'b0;
    RD_ADDR    = '0;
    model_reset();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset_outputs("reset");
    RST = 1'b0;

    // Data before any marker is dropped
    send_word(10'h007);
    read_check(7);

    // Basic frame
    send_word(10'h1FF);
    send_word(10'h1FF);
    send_word(10'h005);
    send_word(10'h003);
    read_check(5);
    read_check(3);
    read_check(4);

    // Duplicate index keeps first rank; extra marker is harmless
    send_word(10'h1FF);
    send_word(10'h1FF);
    send_word(10'h1FF);
    send_word(10'h009);
    send_word(10'h009);
    read_check(9);
    send_word(10'h2AB);
    send_word(10'h3FF);

    // Random mix of markers, data, junk
    for (int k = 0; k < 80; k++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 2)      w = 10'h1FF;
      else if (sel <= 7) w = {2'b00, 8'($urandom_range(0, 15))};
      else if (sel == 8) w = {2'($urandom_range(2, 3)), 8'($urandom)};
      else               w = {2'b01, 8'($urandom_range(250, 255))};
      send_word(w);
      read_check(int'($urandom_range(0, 15)));
    end

    // Full frame, descending order
    send_word(10'h1FF);
    send_word(10'h1FF);
    for (int i = 255; i >= 0; i--) begin
      send_word({2'b00, 8'(i)});
    end
    send_word(10'h080);
    read_check(255);
    read_check(0);
    for (int k = 0; k < 10; k++) read_check(int'($urandom_range(0, 255)));

    // Broken marker pair does not reopen; the next marker completes a pair
    send_word(10'h1FF);
    send_word(10'h004);
    send_word(10'h1FF);
    read_check(4);
    send_word(10'h1FF);
    read_check(4);
    read_check(200);

    // First and second events of a frame
    send_word(10'h00C);
    send_word(10'h00D);
    read_check(12);
    read_check(13);

    // Reset while ACK is high
    AERIN_ADDR = 10'h010;
    AERIN_REQ  = 1'b1;
    RD_ADDR    = 8'd12;
    for (int c = 0; c < 8 && AERIN_ACK !== 1'b1; c++) begin
      @(posedge CLK); @(negedge CLK);
    end
    check("ack_before_reset", 32'(AERIN_ACK), 32'd1);
    RST = 1'b1;
    @(posedge CLK); @(negedge CLK);
    check_reset_outputs("midreset");
    AERIN_REQ = 1'b0;
    @(posedge CLK); @(negedge CLK);
    RST = 1'b0;
    model_reset();
    read_check(12);
    send_word(10'h011);
    send_word(10'h1FF);
    send_word(10'h1FF);
    send_word(10'h011);
    read_check(17);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
